// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
//   gnt_e   : grant type, also used as the in-flight response tag
//   *_DEF   : default widths and starvation limit
//   MASK_W  : byte-enable width; WMASK_NONE is the "no write" mask
package dmem_arb_pkg;

  localparam int unsigned ADDR_W_DEF   = 10;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned MAX_WAIT_DEF = 4;
  localparam int unsigned MASK_W       = 4;
  localparam int unsigned CNT_W        = 4;

  localparam logic [MASK_W-1:0] WMASK_NONE = '0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DBG  = 2'd2
  } gnt_e;

  // Loads must never write: only a store passes its byte mask to the RAM.
  function automatic logic [MASK_W-1:0] store_mask(input logic we,
                                                   input logic [MASK_W-1:0] mask);
    return we ? mask : WMASK_NONE;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU data port, debug reader port and RAM port of the arbiter.
//   slave  : seen by the arbiter (takes CPU/debug requests and RAM data,
//            drives stall, responses and RAM controls)
//   master : seen by the environment (CPU, debug reader, RAM model)
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  // CPU load/store port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [MASK_W-1:0] cpu_wmask;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  // Debug/display reader
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_busy;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_rvalid;

  // Block RAM port A
  logic              ram_ena;
  logic [MASK_W-1:0] ram_wea;
  logic [ADDR_W-1:0] ram_addra;
  logic [DATA_W-1:0] ram_dina;
  logic [DATA_W-1:0] ram_douta;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  dbg_req, dbg_addr,
    output dbg_busy, dbg_rdata, dbg_rvalid,
    output ram_ena, ram_wea, ram_addra, ram_dina,
    input  ram_douta
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output dbg_req, dbg_addr,
    input  dbg_busy, dbg_rdata, dbg_rvalid,
    input  ram_ena, ram_wea, ram_addra, ram_dina,
    output ram_douta
  );

endinterface

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: saturating count of cycles a debug request has been denied.
//   clk, rstn : clock, async active-low reset
//   clr       : restart from zero (debug granted); wins over inc
//   inc       : one more denied cycle
//   sat_c     : count has reached MAX_WAIT (decoded from the count register)
module arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic inc,
  output logic sat_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign sat_c = (cnt_q == CNT_W'(MAX_WAIT));

  // Next count: clear has priority, increments stop at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data block RAM between the CPU load/store port and
// the debug/display reader. The CPU wins by default; a debug request denied
// MAX_WAIT cycles takes one slot and stalls the CPU for that cycle.
//   clk, rstn : clock, async active-low reset
//   bus       : dmem_arbiter_if.slave (CPU port, debug port, RAM port A)
// Grant and RAM drive are combinational; responses appear the cycle after the
// grant, steered by a registered tag recording who issued the read.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  dmem_arbiter_if.slave  bus
);

  // wait_q: a debug request is latched and still waiting for its grant.
  // Once granted it is tracked by tag_q until its response cycle.
  logic              wait_q;
  logic              wait_d;
  logic [ADDR_W-1:0] dbg_addr_q;
  logic [ADDR_W-1:0] dbg_addr_d;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_d;
  gnt_e              tag_q;
  gnt_e              tag_d;

  gnt_e              gnt;
  logic              busy;
  logic              starve_sat;
  logic              starve_inc;
  logic              starve_clr;

  arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (starve_clr),
    .inc   (starve_inc),
    .sat_c (starve_sat)
  );

  // Grant selection and RAM drive; nothing is granted while reset is held.
  always_comb begin : grant_ram
    gnt           = GNT_NONE;
    bus.cpu_stall = 1'b0;
    bus.ram_ena   = 1'b0;
    bus.ram_wea   = WMASK_NONE;
    bus.ram_addra = '0;
    bus.ram_dina  = '0;

    if (rstn) begin
      if (wait_q && starve_sat) begin
        gnt           = GNT_DBG;
        bus.cpu_stall = bus.cpu_req;
      end else if (bus.cpu_req) begin
        gnt = GNT_CPU;
      end else if (wait_q) begin
        gnt = GNT_DBG;
      end
    end

    case (gnt)
      GNT_CPU: begin
        bus.ram_ena   = 1'b1;
        bus.ram_addra = bus.cpu_addr;
        bus.ram_dina  = bus.cpu_wdata;
        bus.ram_wea   = store_mask(bus.cpu_we, bus.cpu_wmask);
      end
      GNT_DBG: begin
        bus.ram_ena   = 1'b1;
        bus.ram_addra = dbg_addr_q;
      end
      default: ;
    endcase
  end

  // Response steering from the tag of last cycle's grant.
  always_comb begin : responses
    busy           = wait_q || (tag_q == GNT_DBG);
    bus.dbg_busy   = busy;
    bus.cpu_rvalid = (tag_q == GNT_CPU);
    bus.cpu_rdata  = (tag_q == GNT_CPU) ? bus.ram_douta : '0;
    bus.dbg_rvalid = (tag_q == GNT_DBG);
    // Fresh RAM data in the response cycle, the held copy afterwards.
    bus.dbg_rdata  = (tag_q == GNT_DBG) ? bus.ram_douta : dbg_rdata_q;
  end

  // Next-state: tag, debug capture/retire, held debug data, starvation control.
  always_comb begin : next_state
    tag_d       = GNT_NONE;
    wait_d      = wait_q;
    dbg_addr_d  = dbg_addr_q;
    dbg_rdata_d = dbg_rdata_q;
    starve_clr  = (gnt == GNT_DBG);
    starve_inc  = wait_q && (gnt != GNT_DBG);

    // Stores produce no response, so only loads are tagged CPU.
    if (gnt == GNT_DBG) begin
      tag_d = GNT_DBG;
    end else if ((gnt == GNT_CPU) && !bus.cpu_we) begin
      tag_d = GNT_CPU;
    end

    // A request while busy is dropped; capture and debug grant are exclusive.
    if (bus.dbg_req && !busy) begin
      wait_d     = 1'b1;
      dbg_addr_d = bus.dbg_addr;
    end else if (gnt == GNT_DBG) begin
      wait_d = 1'b0;
    end

    if (tag_q == GNT_DBG) begin
      dbg_rdata_d = bus.ram_douta;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_q      <= 1'b0;
      dbg_addr_q  <= '0;
      dbg_rdata_q <= '0;
      tag_q       <= GNT_NONE;
    end else begin
      wait_q      <= wait_d;
      dbg_addr_q  <= dbg_addr_d;
      dbg_rdata_q <= dbg_rdata_d;
      tag_q       <= tag_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a behavioural
// 1-cycle block RAM (plus a backdoor preload port) and a cycle-level reference
// model of the arbitration rules for the randomized run.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_WAIT = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // RAM model: synchronous read, byte writes, backdoor preload.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              bd_we   = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [DATA_W-1:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (bus.ram_ena) begin
      bus.ram_douta <= mem[bus.ram_addra];
      for (int b = 0; b < 4; b++) begin
        if (bus.ram_wea[b]) mem[bus.ram_addra][b*8 +: 8] <= bus.ram_dina[b*8 +: 8];
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_in();
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_wmask = '0;
    bus.dbg_req   = 1'b0;
    bus.dbg_addr  = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = d;
    next_cycle();
    bd_we   = 1'b0;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    idle_in();
    next_cycle();
    next_cycle();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn          = 1'b0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_wmask = 4'hF;
    bus.cpu_addr  = 10'h3FF;
    bus.cpu_wdata = 32'hFFFF_FFFF;
    bus.dbg_req   = 1'b1;
    bus.dbg_addr  = 10'h001;
    @(negedge clk);
    n_cmp++;
    if ({bus.ram_ena, bus.ram_wea, bus.ram_addra, bus.ram_dina, bus.cpu_stall} !== '0) begin
      n_err++;
      $display("FAIL reset_ram_side: ena=%b wea=%b addr=%h dina=%h stall=%b, want all 0",
               bus.ram_ena, bus.ram_wea, bus.ram_addra, bus.ram_dina, bus.cpu_stall);
    end
    n_cmp++;
    if ({bus.dbg_busy, bus.dbg_rvalid, bus.cpu_rvalid} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: busy/dv/cv=%b want 000",
               {bus.dbg_busy, bus.dbg_rvalid, bus.cpu_rvalid});
    end
    n_cmp++;
    if ({bus.dbg_rdata, bus.cpu_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_data: dbg_rdata=%h cpu_rdata=%h want 0", bus.dbg_rdata, bus.cpu_rdata);
    end
    next_cycle();
    idle_in();
    rstn = 1'b1;
    next_cycle();
  endtask

  task automatic test_cpu_load();
    poke(10'h010, 32'hDEAD_BEEF);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 10'h010;
    @(negedge clk);
    n_cmp++;
    if ({bus.cpu_stall, bus.ram_ena, bus.ram_wea, bus.ram_addra} !== {1'b0, 1'b1, 4'b0000, 10'h010}) begin
      n_err++;
      $display("FAIL load_grant: stall=%b ena=%b wea=%b addr=%h want 0 1 0000 010",
               bus.cpu_stall, bus.ram_ena, bus.ram_wea, bus.ram_addra);
    end
    next_cycle();
    idle_in();
    @(negedge clk);
    n_cmp++;
    if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      n_err++;
      $display("FAIL load_resp: rvalid=%b rdata=%h want 1 deadbeef", bus.cpu_rvalid, bus.cpu_rdata);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL load_gated: rvalid=%b rdata=%h want 0 0", bus.cpu_rvalid, bus.cpu_rdata);
    end
    next_cycle();
  endtask

  task automatic test_dbg_idle();
    poke(10'h020, 32'h1234_5678);
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 10'h020;
    @(negedge clk);
    n_cmp++;
    if ({bus.dbg_busy, bus.ram_ena} !== 2'b00) begin
      n_err++;
      $display("FAIL dbg_req_cycle: busy=%b ena=%b want 0 0", bus.dbg_busy, bus.ram_ena);
    end
    next_cycle();
    bus.dbg_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.dbg_busy, bus.ram_ena, bus.ram_wea, bus.ram_addra, bus.dbg_rvalid} !==
        {1'b1, 1'b1, 4'b0000, 10'h020, 1'b0}) begin
      n_err++;
      $display("FAIL dbg_grant: busy=%b ena=%b wea=%b addr=%h dv=%b want 1 1 0000 020 0",
               bus.dbg_busy, bus.ram_ena, bus.ram_wea, bus.ram_addra, bus.dbg_rvalid);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({bus.dbg_rvalid, bus.dbg_busy, bus.dbg_rdata} !== {1'b1, 1'b1, 32'h1234_5678}) begin
      n_err++;
      $display("FAIL dbg_resp: dv=%b busy=%b rdata=%h want 1 1 12345678",
               bus.dbg_rvalid, bus.dbg_busy, bus.dbg_rdata);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({bus.dbg_rvalid, bus.dbg_busy, bus.dbg_rdata} !== {1'b0, 1'b0, 32'h1234_5678}) begin
      n_err++;
      $display("FAIL dbg_after: dv=%b busy=%b rdata=%h want 0 0 12345678 (held)",
               bus.dbg_rvalid, bus.dbg_busy, bus.dbg_rdata);
    end
    next_cycle();
  endtask

  // CPU loads every cycle; debug requests at k=0 and k=7 must each be forced
  // in after MAX_WAIT denied cycles, with the counter restarting in between.
  task automatic test_starvation();
    logic [DATA_W-1:0] d0;
    logic [2:0]        want;
    d0 = $urandom;
    poke(10'h040, d0);
    for (int k = 0; k < 15; k++) begin
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = ADDR_W'($urandom_range(0, 63));
      bus.dbg_req  = (k == 0) || (k == 7);
      bus.dbg_addr = 10'h040;
      @(negedge clk);
      want = {(k == 5) || (k == 12), (k == 6) || (k == 13),
              (k >= 1) && (k != 6) && (k != 13)};
      n_cmp++;
      if ({bus.cpu_stall, bus.dbg_rvalid, bus.cpu_rvalid} !== want) begin
        n_err++;
        $display("FAIL starve_k%0d: stall/dv/cv=%b want %b", k,
                 {bus.cpu_stall, bus.dbg_rvalid, bus.cpu_rvalid}, want);
      end
      if (want[1]) begin
        n_cmp++;
        if (bus.dbg_rdata !== d0) begin
          n_err++;
          $display("FAIL starve_data_k%0d: dbg_rdata=%h want %h", k, bus.dbg_rdata, d0);
        end
      end
      next_cycle();
    end
    idle_in();
    next_cycle();
  endtask

  task automatic test_byte_store();
    bit seen;
    seen = 1'b0;
    poke(10'h004, 32'h1122_3344);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_wmask = 4'b0010;
    bus.cpu_wdata = 32'h0000_AB00;
    bus.cpu_addr  = 10'h004;
    @(negedge clk);
    n_cmp++;
    if ({bus.ram_ena, bus.ram_wea, bus.ram_addra, bus.ram_dina} !==
        {1'b1, 4'b0010, 10'h004, 32'h0000_AB00}) begin
      n_err++;
      $display("FAIL store_drive: ena=%b wea=%b addr=%h dina=%h want 1 0010 004 0000ab00",
               bus.ram_ena, bus.ram_wea, bus.ram_addra, bus.ram_dina);
    end
    next_cycle();
    idle_in();
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 10'h004;
    @(negedge clk);
    n_cmp++;
    if (bus.cpu_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL store_no_rvalid: cpu_rvalid=%b want 0", bus.cpu_rvalid);
    end
    next_cycle();
    bus.dbg_req = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.dbg_rvalid === 1'b1) begin
        seen = 1'b1;
        n_cmp++;
        if (bus.dbg_rdata !== 32'h1122_AB44) begin
          n_err++;
          $display("FAIL store_readback: dbg_rdata=%h want 1122ab44", bus.dbg_rdata);
        end
      end
      next_cycle();
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL store_readback_timeout: dbg_rvalid seen=0 want 1 within 10 cycles");
    end
    next_cycle();
  endtask

  task automatic test_busy_drop();
    poke(10'h024, 32'hCAFE_F00D);
    poke(10'h030, 32'h3030_3030);
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 10'h024;
    next_cycle();
    bus.dbg_addr = 10'h030;
    @(negedge clk);
    n_cmp++;
    if ({bus.dbg_busy, bus.ram_addra} !== {1'b1, 10'h024}) begin
      n_err++;
      $display("FAIL busy_grant: busy=%b addr=%h want 1 024", bus.dbg_busy, bus.ram_addra);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({bus.dbg_rvalid, bus.dbg_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
      n_err++;
      $display("FAIL busy_resp: dv=%b rdata=%h want 1 cafef00d", bus.dbg_rvalid, bus.dbg_rdata);
    end
    next_cycle();
    bus.dbg_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.dbg_rvalid, bus.dbg_busy, bus.ram_ena} !== 3'b000) begin
        n_err++;
        $display("FAIL busy_dropped_k%0d: dv/busy/ena=%b want 000", k,
                 {bus.dbg_rvalid, bus.dbg_busy, bus.ram_ena});
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_midflight();
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 10'h020;
    next_cycle();
    bus.dbg_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.ram_ena, bus.ram_addra} !== {1'b1, 10'h020}) begin
      n_err++;
      $display("FAIL midflight_grant: ena=%b addr=%h want 1 020", bus.ram_ena, bus.ram_addra);
    end
    next_cycle();
    rstn = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.dbg_rvalid, bus.dbg_busy, bus.cpu_rvalid, bus.ram_ena, bus.cpu_stall, bus.dbg_rdata} !== '0) begin
      n_err++;
      $display("FAIL midflight_reset: dv=%b busy=%b cv=%b ena=%b stall=%b rdata=%h want all 0",
               bus.dbg_rvalid, bus.dbg_busy, bus.cpu_rvalid, bus.ram_ena, bus.cpu_stall, bus.dbg_rdata);
    end
    next_cycle();
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.dbg_rvalid, bus.dbg_busy, bus.cpu_rvalid, bus.ram_ena} !== 4'b0000) begin
        n_err++;
        $display("FAIL midflight_after_k%0d: dv/busy/cv/ena=%b want 0000", k,
                 {bus.dbg_rvalid, bus.dbg_busy, bus.cpu_rvalid, bus.ram_ena});
      end
      next_cycle();
    end
  endtask

  // Randomized traffic over 32 words against a model of the arbitration rules.
  task automatic test_random();
    logic [DATA_W-1:0] emem [0:31];
    bit                m_wait;
    int                m_waited;
    logic [ADDR_W-1:0] m_addr;
    int                m_resp;
    logic [DATA_W-1:0] m_resp_data;
    logic [DATA_W-1:0] m_hold;
    int                gnt;
    bit                busy;
    logic [ADDR_W-1:0] gaddr;
    logic [3:0]        ewea;
    logic [DATA_W-1:0] ecpu;
    logic [DATA_W-1:0] edbg;

    apply_reset();
    for (int i = 0; i < 32; i++) begin
      emem[i] = $urandom;
      poke(ADDR_W'(i), emem[i]);
    end
    m_wait = 1'b0; m_waited = 0; m_addr = '0;
    m_resp = 0; m_resp_data = '0; m_hold = '0;

    for (int i = 0; i < 3000; i++) begin
      bus.cpu_req   = ($urandom_range(0, 9) < 6);
      bus.cpu_we    = ($urandom_range(0, 2) == 0);
      bus.cpu_addr  = ADDR_W'($urandom_range(0, 31));
      bus.cpu_wmask = 4'($urandom);
      bus.cpu_wdata = $urandom;
      bus.dbg_req   = ($urandom_range(0, 3) == 0);
      bus.dbg_addr  = ADDR_W'($urandom_range(0, 31));

      busy = m_wait || (m_resp == 2);
      if (m_wait && m_waited >= int'(MAX_WAIT)) gnt = 2;
      else if (bus.cpu_req)                     gnt = 1;
      else if (m_wait)                          gnt = 2;
      else                                      gnt = 0;
      gaddr = (gnt == 1) ? bus.cpu_addr : m_addr;
      ewea  = (gnt == 1 && bus.cpu_we) ? bus.cpu_wmask : 4'b0000;
      ecpu  = (m_resp == 1) ? m_resp_data : '0;
      edbg  = (m_resp == 2) ? m_resp_data : m_hold;

      @(negedge clk);
      n_cmp++;
      if ({bus.cpu_stall, bus.ram_ena, bus.ram_wea} !== {gnt == 2 && bus.cpu_req == 1'b1, gnt != 0, ewea}) begin
        n_err++;
        $display("FAIL rnd_grant_c%0d: stall=%b ena=%b wea=%b want %b %b %b", i,
                 bus.cpu_stall, bus.ram_ena, bus.ram_wea, gnt == 2 && bus.cpu_req == 1'b1, gnt != 0, ewea);
      end
      if (gnt != 0) begin
        n_cmp++;
        if (bus.ram_addra !== gaddr) begin
          n_err++;
          $display("FAIL rnd_addr_c%0d: addr=%h want %h", i, bus.ram_addra, gaddr);
        end
      end
      if (gnt == 1) begin
        n_cmp++;
        if (bus.ram_dina !== bus.cpu_wdata) begin
          n_err++;
          $display("FAIL rnd_dina_c%0d: dina=%h want %h", i, bus.ram_dina, bus.cpu_wdata);
        end
      end
      n_cmp++;
      if ({bus.cpu_rvalid, bus.dbg_rvalid, bus.dbg_busy} !== {m_resp == 1, m_resp == 2, busy}) begin
        n_err++;
        $display("FAIL rnd_flags_c%0d: cv/dv/busy=%b want %b", i,
                 {bus.cpu_rvalid, bus.dbg_rvalid, bus.dbg_busy}, {m_resp == 1, m_resp == 2, busy});
      end
      n_cmp++;
      if ({bus.cpu_rdata, bus.dbg_rdata} !== {ecpu, edbg}) begin
        n_err++;
        $display("FAIL rnd_data_c%0d: cpu_rdata=%h dbg_rdata=%h want %h %h", i,
                 bus.cpu_rdata, bus.dbg_rdata, ecpu, edbg);
      end

      if (m_resp == 2) m_hold = m_resp_data;
      m_resp      = (gnt == 2) ? 2 : ((gnt == 1 && !bus.cpu_we) ? 1 : 0);
      m_resp_data = emem[gaddr[4:0]];
      if (gnt == 1 && bus.cpu_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.cpu_wmask[b]) emem[gaddr[4:0]][b*8 +: 8] = bus.cpu_wdata[b*8 +: 8];
        end
      end
      if (gnt == 2) begin
        m_wait   = 1'b0;
        m_waited = 0;
      end else if (m_wait) begin
        m_waited++;
      end
      if (bus.dbg_req && !busy) begin
        m_wait   = 1'b1;
        m_waited = 0;
        m_addr   = bus.dbg_addr;
      end
      next_cycle();
    end
    idle_in();
    next_cycle();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_cpu_load();
    test_dbg_idle();
    test_starvation();
    test_byte_store();
    test_busy_drop();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
